alu: RTL and testbench

Parameterised integer ALU with a single registered output stage. It sits on a datapath as a leaf block and selects one result per cycle: bypass of A, bypass of B, bitwise AND, add with carry-in, subtract, or XOR-reduction of B. Results and carry/borrow are captured on the clock edge and held until the next valid operation.

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_if.sv | 35 +++
 rtl/alu_datapath.sv | 57 +++++
 rtl/alu.sv | 56 +++++
 tb/tb_alu.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode encodings and default operand width for the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_XORR = 2'b11;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_if
// Description : Operand/control bundle and registered result bundle of the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_if
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cin;
    logic             pass_A;
    logic             pass_B;
    logic [1:0]       opcode;
    logic [WIDTH-1:0] out;
    logic             cout;
    logic             out_valid;

    modport master (
        output in_valid, A, B, cin, pass_A, pass_B, opcode,
        input  out, cout, out_valid
    );

    modport slave (
        input  in_valid, A, B, cin, pass_A, pass_B, opcode,
        output out, cout, out_valid
    );

endinterface : alu_if
`default_nettype wire

// File: rtl/alu_datapath.sv
`default_nettype none
// ============================================================================
// Module      : alu_datapath
// Description : Combinational result/carry selection feeding the ALU registers.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_datapath
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  wire logic [WIDTH-1:0] i_a,
    input  wire logic [WIDTH-1:0] i_b,
    input  wire logic             i_cin,
    input  wire logic             i_pass_a,
    input  wire logic             i_pass_b,
    input  wire logic [1:0]       i_opcode,
    output logic      [WIDTH-1:0] o_next_out,
    output logic                  o_next_cout
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;

    // One extra bit so the MSB of the difference is the borrow (A < B).
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    always_comb begin
        o_next_out  = '0;
        o_next_cout = 1'b0;
        if (i_pass_a) begin
            o_next_out = i_a;
        end else if (i_pass_b) begin
            o_next_out = i_b;
        end else begin
            case (i_opcode)
                OP_AND: begin
                    o_next_out = i_a & i_b;
                end
                OP_ADD: begin
                    o_next_out  = w_sum[WIDTH-1:0];
                    o_next_cout = w_sum[WIDTH];
                end
                OP_SUB: begin
                    o_next_out  = w_diff[WIDTH-1:0];
                    o_next_cout = w_diff[WIDTH];
                end
                default: begin
                    o_next_out = {{(WIDTH-1){1'b0}}, ^i_b};
                end
            endcase
        end
    end

endmodule : alu_datapath
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : Integer ALU with a single registered result/carry/valid stage.
// Revision    : 1.0 - initial release
// ============================================================================
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  wire logic clk,
    input  wire logic rst,
    alu_if.slave      bus
);

    logic [WIDTH-1:0] w_next_out;
    logic             w_next_cout;
    logic [WIDTH-1:0] r_out;
    logic             r_cout;
    logic             r_out_valid;

    alu_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .i_a         (bus.A),
        .i_b         (bus.B),
        .i_cin       (bus.cin),
        .i_pass_a    (bus.pass_A),
        .i_pass_b    (bus.pass_B),
        .i_opcode    (bus.opcode),
        .o_next_out  (w_next_out),
        .o_next_cout (w_next_cout)
    );

    // Result registers hold across idle cycles; reset drops any concurrent operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out       <= '0;
            r_cout      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_out  <= w_next_out;
                r_cout <= w_next_cout;
            end
        end
    end

    assign bus.out       = r_out;
    assign bus.cout      = r_cout;
    assign bus.out_valid = r_out_valid;

endmodule : alu
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu
// Description : Directed and randomized self-checking bench for the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu;

    localparam int WIDTH = 4;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_err    = 0;

    logic [WIDTH-1:0] m_out;
    logic             m_cout;
    logic             m_valid;

    alu_if #(.WIDTH(WIDTH)) bus ();

    alu #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference: result as plain integer arithmetic, returns {cout, out}.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic c, input logic pa, input logic pb,
                                             input logic [1:0] op);
        int             s;
        int             m;
        logic [WIDTH:0] r;
        m = 1 << WIDTH;
        r = '0;
        if (pa) begin
            r = {1'b0, a};
        end else if (pb) begin
            r = {1'b0, b};
        end else if (op == 2'd0) begin
            r = {1'b0, a & b};
        end else if (op == 2'd1) begin
            s = int'(a) + int'(b) + int'(c);
            r[WIDTH-1:0] = WIDTH'(s % m);
            r[WIDTH]     = (s >= m);
        end else if (op == 2'd2) begin
            s = int'(a) - int'(b);
            r[WIDTH-1:0] = WIDTH'((s + m) % m);
            r[WIDTH]     = (int'(a) < int'(b));
        end else begin
            s = 0;
            for (int i = 0; i < WIDTH; i++) s = s + int'(b[i]);
            r = (WIDTH+1)'(s % 2);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then compare DUT against the running model.
    task automatic step(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic c, input logic pa, input logic pb, input logic [1:0] op);
        @(negedge clk);
        bus.in_valid = v;
        bus.A        = a;
        bus.B        = b;
        bus.cin      = c;
        bus.pass_A   = pa;
        bus.pass_B   = pb;
        bus.opcode   = op;
        @(posedge clk);
        #1;
        if (rst) begin
            m_out   = '0;
            m_cout  = 1'b0;
            m_valid = 1'b0;
        end else begin
            m_valid = v;
            if (v) {m_cout, m_out} = model(a, b, c, pa, pb, op);
        end
        chk("model_out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("model_out", 32'(bus.out), 32'(m_out));
        chk("model_cout", 32'(bus.cout), 32'(m_cout));
    endtask

    task automatic expect_res(input string tag, input logic [WIDTH-1:0] eo, input logic ec);
        chk({tag, "_out"}, 32'(bus.out), 32'(eo));
        chk({tag, "_cout"}, 32'(bus.cout), 32'(ec));
    endtask

    initial begin
        logic [WIDTH-1:0] h_out;
        logic             h_cout;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.A        = '0;
        bus.B        = '0;
        bus.cin      = 1'b0;
        bus.pass_A   = 1'b0;
        bus.pass_B   = 1'b0;
        bus.opcode   = 2'b00;

        // Reset wins over a concurrent valid ADD.
        step(1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 2'b01);
        expect_res("reset1", 4'd0, 1'b0);
        chk("reset1_valid", 32'(bus.out_valid), 32'd0);
        step(1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 2'b01);
        expect_res("reset2", 4'd0, 1'b0);
        chk("reset2_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        step(1'b1, 4'd5, 4'd9, 1'b0, 1'b1, 1'b1, 2'b01);
        expect_res("pass_a_prio", 4'd5, 1'b0);
        step(1'b1, 4'd5, 4'd9, 1'b0, 1'b0, 1'b1, 2'b01);
        expect_res("pass_b", 4'd9, 1'b0);

        step(1'b1, 4'd15, 4'd1, 1'b0, 1'b0, 1'b0, 2'b01);
        expect_res("add_15_1", 4'd0, 1'b1);
        step(1'b1, 4'd7, 4'd8, 1'b1, 1'b0, 1'b0, 2'b01);
        expect_res("add_7_8_c", 4'd0, 1'b1);
        step(1'b1, 4'd3, 4'd4, 1'b1, 1'b0, 1'b0, 2'b01);
        expect_res("add_3_4_c", 4'd8, 1'b0);

        step(1'b1, 4'd9, 4'd4, 1'b1, 1'b0, 1'b0, 2'b10);
        expect_res("sub_9_4", 4'd5, 1'b0);
        step(1'b1, 4'd2, 4'd5, 1'b0, 1'b0, 1'b0, 2'b10);
        expect_res("sub_2_5", 4'd13, 1'b1);
        step(1'b1, 4'd6, 4'd6, 1'b0, 1'b0, 1'b0, 2'b10);
        expect_res("sub_6_6", 4'd0, 1'b0);

        step(1'b1, 4'b1100, 4'b1010, 1'b1, 1'b0, 1'b0, 2'b00);
        expect_res("and", 4'b1000, 1'b0);
        step(1'b1, 4'b1111, 4'b1011, 1'b1, 1'b0, 1'b0, 2'b11);
        expect_res("xorr_1011", 4'd1, 1'b0);
        step(1'b1, 4'b1111, 4'b0110, 1'b1, 1'b0, 1'b0, 2'b11);
        expect_res("xorr_0110", 4'd0, 1'b0);

        // Four back-to-back operations, then idle cycles with changing inputs.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 4'($urandom), 4'($urandom), 1'($urandom), 1'b0, 1'b0, 2'($urandom));
            chk("burst_valid", 32'(bus.out_valid), 32'd1);
        end
        h_out  = bus.out;
        h_cout = bus.cout;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom));
            expect_res("hold", h_out, h_cout);
            chk("hold_valid", 32'(bus.out_valid), 32'd0);
        end

        for (int i = 0; i < 1000; i++) begin
            step(($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), 1'($urandom),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 2'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule : tb_alu
`default_nettype wire
